// File: rtl/mux_dest_pkg.sv
// mux_dest_pkg: shared constants and helpers for the destination mux.
// Arbitration mode encodings and a one-hot encoder.
package mux_dest_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_CH     = 32;

  function automatic logic [MAX_CH-1:0] onehot(
    input int idx,
    input int n
  );
    logic [MAX_CH-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_CH)
      v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_dest.sv
// rr_arbiter_dest: winner search (fixed or round-robin with burst lock).
// in: clk, reset_L, fifo_empty, dest_almost_full; out: pop, winner.
module rr_arbiter_dest
  import mux_dest_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int MODE      = MODE_RR,
  parameter int MAX_BURST = 1,
  parameter int IW        = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [N_CH-1:0] fifo_empty,
  input  logic            dest_almost_full,
  output logic [N_CH-1:0] pop,
  output logic [IW-1:0]   winner
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [IW-1:0]   cur;
  logic [BW-1:0]   bcnt;
  logic            lock;
  logic [N_CH-1:0] req;
  logic            issue;
  logic            hold;
  logic            found;
  int              idx;

  assign req   = ~fifo_empty;
  assign issue = reset_L & ~dest_almost_full & (|req);

  // Stay on the current channel while its burst has room left.
  assign hold = (MODE == MODE_RR) && lock && req[cur]
             && (int'(bcnt) < MAX_BURST - 1);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (MODE == MODE_FIXED) begin
      for (int i = N_CH - 1; i >= 0; i--)
        if (req[i]) winner = IW'(i);
    end else if (hold) begin
      winner = cur;
    end else begin
      // cur+1 first, cur itself last.
      for (int k = 1; k <= N_CH; k++) begin
        idx = (int'(cur) + k) % N_CH;
        if (!found && req[idx]) begin
          winner = IW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign pop = issue ? N_CH'(onehot(int'(winner), N_CH)) : '0;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cur  <= IW'(N_CH - 1);
      bcnt <= '0;
      lock <= 1'b0;
    end else if (issue) begin
      if (winner == cur && lock) begin
        // Saturate: a lone channel keeps winning past the burst limit.
        if (int'(bcnt) < MAX_BURST - 1)
          bcnt <= bcnt + 1'b1;
      end else begin
        bcnt <= '0;
        cur  <= winner;
      end
      lock <= 1'b1;
    end else begin
      bcnt <= '0;
      lock <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_dest_arb.sv
// mux_dest_arb: N-channel FWFT-FIFO destination mux, one word per cycle.
// in: clk, reset_L, fifo_empty, fifo_data, dest_almost_full;
// out: pop (comb), valid_out, data_out, grant_id (registered).
module mux_dest_arb
  import mux_dest_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 10,
  parameter int MODE      = MODE_RR,
  parameter int MAX_BURST = 1
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [N_CH-1:0]          fifo_empty,
  input  logic [N_CH*DATA_W-1:0]   fifo_data,
  input  logic                     dest_almost_full,
  output logic [N_CH-1:0]          pop,
  output logic                     valid_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(N_CH)-1:0]  grant_id
);

  localparam int IW = $clog2(N_CH);

  logic [IW-1:0] winner;

  rr_arbiter_dest #(
    .N_CH      (N_CH),
    .MODE      (MODE),
    .MAX_BURST (MAX_BURST),
    .IW        (IW)
  ) u_arb (
    .clk              (clk),
    .reset_L          (reset_L),
    .fifo_empty       (fifo_empty),
    .dest_almost_full (dest_almost_full),
    .pop              (pop),
    .winner           (winner)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      grant_id  <= '0;
    end else if (|pop) begin
      valid_out <= 1'b1;
      data_out  <= fifo_data[int'(winner)*DATA_W +: DATA_W];
      grant_id  <= winner;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_dest_arb.sv
// tb_mux_dest_arb: three instances (RR burst 1, RR burst 3, fixed)
// share one directed stimulus; a scoreboard checks registered outputs.
module tb_mux_dest_arb;
  import mux_dest_pkg::*;

  localparam logic [9:0] D0 = 10'h2DA;
  localparam logic [9:0] D1 = 10'h35A;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [1:0]  fifo_empty = 2'b00;
  logic        daf = 1'b0;
  logic [19:0] fifo_data;

  assign fifo_data = {D1, D0};

  always #5 clk = ~clk;

  logic [1:0] pop_o [3];
  logic       vld_o [3];
  logic [9:0] dat_o [3];
  logic [0:0] gid_o [3];

  mux_dest_arb #(
    .N_CH(2), .DATA_W(10), .MODE(MODE_RR), .MAX_BURST(1)
  ) u_rr1 (
    .clk(clk), .reset_L(reset_L),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .dest_almost_full(daf), .pop(pop_o[0]),
    .valid_out(vld_o[0]), .data_out(dat_o[0]),
    .grant_id(gid_o[0])
  );

  mux_dest_arb #(
    .N_CH(2), .DATA_W(10), .MODE(MODE_RR), .MAX_BURST(3)
  ) u_rr3 (
    .clk(clk), .reset_L(reset_L),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .dest_almost_full(daf), .pop(pop_o[1]),
    .valid_out(vld_o[1]), .data_out(dat_o[1]),
    .grant_id(gid_o[1])
  );

  mux_dest_arb #(
    .N_CH(2), .DATA_W(10), .MODE(MODE_FIXED), .MAX_BURST(3)
  ) u_fix (
    .clk(clk), .reset_L(reset_L),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .dest_almost_full(daf), .pop(pop_o[2]),
    .valid_out(vld_o[2]), .data_out(dat_o[2]),
    .grant_id(gid_o[2])
  );

  typedef struct packed {
    logic [2:0]      v;
    logic [2:0][9:0] d;
    logic [2:0]      g;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] fe;
    logic       daf;
    logic       pls;
    logic [1:0] pa;
    logic [1:0] pb;
    logic [1:0] pc;
  } vec_t;

  // {rst, fifo_empty, daf, reset pulse, pop rr1, pop rr3, pop fixed}
  localparam int NV = 21;
  localparam logic [10:0] VECS [NV] = '{
    11'b0_00_0_0_00_00_00,
    11'b0_00_0_0_00_00_00,
    11'b1_00_0_0_01_01_01,
    11'b1_00_0_0_10_01_01,
    11'b1_00_0_0_01_01_01,
    11'b1_00_0_0_10_10_01,
    11'b1_00_0_0_01_10_01,
    11'b1_00_0_0_10_10_01,
    11'b1_00_0_0_01_01_01,
    11'b1_00_1_0_00_00_00,
    11'b1_00_0_0_10_10_01,
    11'b1_01_0_0_10_10_10,
    11'b1_01_0_0_10_10_10,
    11'b1_01_0_0_10_10_10,
    11'b1_10_0_0_01_01_01,
    11'b1_00_0_0_10_01_01,
    11'b1_11_0_0_00_00_00,
    11'b1_00_0_0_01_10_01,
    11'b1_00_0_1_01_01_01,
    11'b1_00_0_0_10_01_01,
    11'b1_11_0_0_00_00_00
  };

  exp_t sbq [$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Monitor: one scoreboard entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("valid_out[%0d]", k),
              32'(vld_o[k]), 32'(e.v[k]));
          chk($sformatf("data_out[%0d]", k),
              32'(dat_o[k]), 32'(e.d[k]));
          chk($sformatf("grant_id[%0d]", k),
              32'(gid_o[k]), 32'(e.g[k]));
        end
      end else begin
        for (int k = 0; k < 3; k++)
          chk($sformatf("idle_valid[%0d]", k),
              32'(vld_o[k]), 32'd0);
      end
    end
  end

  // Stimulus: drive at falling edge, check pop, push expectations.
  initial begin
    vec_t       v;
    exp_t       e;
    logic [1:0] ep [3];
    logic [9:0] ld [3];
    logic       lg [3];
    for (int k = 0; k < 3; k++) begin
      ld[k] = '0;
      lg[k] = 1'b0;
    end
    for (int i = 0; i < NV; i++) begin
      v = VECS[i];
      reset_L    = v.rst;
      fifo_empty = v.fe;
      daf        = v.daf;
      if (v.pls) begin
        #1 reset_L = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("pulse_valid[%0d]", k),
              32'(vld_o[k]), 32'd0);
          chk($sformatf("pulse_data[%0d]", k),
              32'(dat_o[k]), 32'd0);
          chk($sformatf("pulse_gid[%0d]", k),
              32'(gid_o[k]), 32'd0);
          chk($sformatf("pulse_pop[%0d]", k),
              32'(pop_o[k]), 32'd0);
          ld[k] = '0;
          lg[k] = 1'b0;
        end
        reset_L = 1'b1;
      end
      #1;
      ep[0] = v.pa;
      ep[1] = v.pb;
      ep[2] = v.pc;
      e = '0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("pop[%0d] row %0d", k, i),
            32'(pop_o[k]), 32'(ep[k]));
        if (!v.rst) begin
          ld[k] = '0;
          lg[k] = 1'b0;
        end else if (ep[k] == 2'b01) begin
          ld[k] = D0;
          lg[k] = 1'b0;
        end else if (ep[k] == 2'b10) begin
          ld[k] = D1;
          lg[k] = 1'b1;
        end
        e.v[k] = v.rst && (ep[k] != 2'b00);
        e.d[k] = ld[k];
        e.g[k] = lg[k];
      end
      sbq.push_back(e);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
